// File: rtl/cpu_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single shared CPU bus.
// Alternates contended grants, inserts a one-cycle release gap and guards each bus cycle with a watchdog.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_ready,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUS_A   = 2'd1;
  localparam logic [1:0] BUS_B   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  localparam logic        WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        lastGrant_q, lastGrant_d;
  logic [15:0] wdCount_q, wdCount_d;
  logic        timeout_q, timeout_d;
  logic        grantReq;
  logic        wdExpired;

  always_comb begin
    grantReq  = (state_q == BUS_A) ? i_pa_request : i_pb_request;
    wdExpired = WD_EN && (wdCount_q == WD_LAST);
  end

  // A dropped request aborts before ready is considered; ready beats the watchdog.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    wdCount_d   = wdCount_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (i_pa_request && (!i_pb_request || lastGrant_q == GRANT_B)) begin
          state_d     = BUS_A;
          lastGrant_d = GRANT_A;
          wdCount_d   = 16'd0;
        end else if (i_pb_request) begin
          state_d     = BUS_B;
          lastGrant_d = GRANT_B;
          wdCount_d   = 16'd0;
        end
      end
      BUS_A, BUS_B: begin
        if (!grantReq) begin
          state_d = RELEASE;
        end else if (i_bus_ready) begin
          state_d = RELEASE;
        end else if (wdExpired) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end else begin
          wdCount_d = wdCount_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      lastGrant_q <= GRANT_B;
      wdCount_q   <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      wdCount_q   <= wdCount_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = 32'h0;
    o_bus_wdata   = 32'h0;
    o_pa_ready    = 1'b0;
    o_pa_rdata    = 32'h0;
    o_pb_ready    = 1'b0;
    o_pb_rdata    = 32'h0;
    case (state_q)
      BUS_A: begin
        o_bus_request = 1'b1;
        o_bus_address = i_pa_address;
        if (i_bus_ready && i_pa_request) begin
          o_pa_ready = 1'b1;
          o_pa_rdata = i_bus_rdata;
        end
      end
      BUS_B: begin
        o_bus_request = 1'b1;
        o_bus_rw      = i_pb_rw;
        o_bus_address = i_pb_address;
        o_bus_wdata   = i_pb_wdata;
        if (i_bus_ready && i_pb_request) begin
          o_pb_ready = 1'b1;
          o_pb_rdata = i_bus_rdata;
        end
      end
      default: ;
    endcase
    o_timeout = timeout_q;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, giving the bus-cycle watchdog limit (0 = watchdog disabled; legal range 0..65535).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, on ports i_clock and i_reset.
REQ-003 SHALL have the following ports, one per line (name  direction  width  meaning):
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous active-high reset.
- i_pa_request  in  1  port A (instruction fetch) request; held until the ready pulse.
- i_pa_address  in  32  port A address.
- o_pa_rdata  out  32  port A read data.
- o_pa_ready  out  1  port A one-cycle completion pulse.
- i_pb_request  in  1  port B (data) request.
- i_pb_rw  in  1  port B direction; 1 = write.
- i_pb_address  in  32  port B address.
- i_pb_wdata  in  32  port B write data.
- o_pb_rdata  out  32  port B read data.
- o_pb_ready  out  1  port B one-cycle completion pulse.
- o_bus_request  out  1  shared bus request.
- o_bus_rw  out  1  shared bus direction.
- o_bus_address  out  32  shared bus address.
- o_bus_wdata  out  32  shared bus write data.
- i_bus_rdata  in  32  shared bus read data.
- i_bus_ready  in  1  shared bus completion.
- o_timeout  out  1  sticky watchdog error flag.

Function
REQ-004 The arbiter SHALL have four states: IDLE, BUS_A, BUS_B and RELEASE.
REQ-005 The arbiter SHALL keep a register last_grant (A/B); the reset value SHALL be B, so the first contended grant goes to A.
REQ-006 In IDLE, the transitions SHALL be:
- only A requesting -> BUS_A;
- only B requesting -> BUS_B;
- both requesting -> the port not equal to last_grant;
- neither requesting -> stay in IDLE.
REQ-007 last_grant SHALL be updated on entry to BUS_A or BUS_B.
REQ-008 Grant latency SHALL be exactly one cycle: a request seen in IDLE in cycle N gives o_bus_request=1 in cycle N+1.
REQ-009 In BUS_A, the bus outputs SHALL be driven combinationally as: o_bus_request=1, o_bus_address=i_pa_address, o_bus_rw=0, o_bus_wdata=0.
REQ-010 In BUS_B, the bus outputs SHALL be driven combinationally as: o_bus_request=1, o_bus_address=i_pb_address, o_bus_rw=i_pb_rw, o_bus_wdata=i_pb_wdata.
REQ-011 In IDLE and RELEASE, all o_bus_* outputs SHALL be 0.
REQ-012 In BUS_x with i_bus_ready=1, the arbiter SHALL, in the same cycle, set o_px_ready=1 and o_px_rdata=i_bus_rdata, and next state SHALL be RELEASE.
REQ-013 Outside that cycle, o_px_ready SHALL be 0 and o_px_rdata SHALL be 32'h0 for both ports.
REQ-014 RELEASE SHALL last exactly one cycle, with o_bus_request=0, then go to IDLE; requests SHALL be ignored during RELEASE.
REQ-015 A requester holding its request after its ready pulse SHALL be re-arbitrated in IDLE like a new request (no fairness exception).
REQ-016 If the granted port's request deasserts in BUS_x before i_bus_ready, the arbiter SHALL go to RELEASE with no ready pulse (abort).
REQ-017 i_bus_ready SHALL be ignored in IDLE and RELEASE.
REQ-018 The non-granted port's request SHALL NOT affect the bus while the other port is granted.
REQ-019 The watchdog counter SHALL be 16 bits, cleared on entry to BUS_x, and incremented each BUS_x cycle without i_bus_ready.
REQ-020 If TIMEOUT>0 and the counter equals TIMEOUT-1 with no i_bus_ready, the arbiter SHALL:
- set o_timeout=1 (sticky);
- go to RELEASE;
- give no ready pulse.
REQ-021 If i_bus_ready and the timeout condition occur in the same cycle, ready SHALL win: normal completion, o_timeout unchanged.

Reset
REQ-022 Asserting i_reset SHALL immediately (asynchronously) force state=IDLE, last_grant=B, counter=0 and o_timeout=0.
REQ-023 While i_reset is asserted, all outputs SHALL be 0; a transaction in flight SHALL be dropped with no ready pulse.
REQ-024 After i_reset deasserts, the first arbitration SHALL occur in the first IDLE cycle.

Verification
REQ-025 The bench SHALL cover the single read: A requests 0x0000_1000; bus ready 3 cycles after grant with rdata 0xDEADBEEF -> o_pa_ready pulses once with o_pa_rdata=0xDEADBEEF, then 1 RELEASE cycle, then IDLE.
REQ-026 The bench SHALL cover the contention sequence: A and B request together from reset -> A granted first, then B; with both held continuously, grants alternate A,B,A,B.
REQ-027 The bench SHALL cover the B write: i_pb_rw=1, address 0x8000_0010, wdata 0x12345678 -> o_bus_rw=1 with that address and data while granted; o_pb_ready pulses on i_bus_ready.
REQ-028 The bench SHALL cover the watchdog: TIMEOUT=4, bus never ready -> o_timeout=1 after the 4th BUS cycle, no ready pulse, state returns to IDLE, and the flag stays set until reset.
REQ-029 The bench SHALL cover abort and reset: A's request drops in BUS_A -> RELEASE with no ready pulse; i_reset asserted mid-BUS_B -> all outputs 0 in the same cycle, and after release A is granted on its next request.
